// File: rtl/serial_word_rx.sv
// serial_word_rx
// Assembles MSB-first serial bits into WIDTH-bit words. A frameStart strobe
// on any valid bit restarts assembly. Completed words move into a holding
// register that a valid/ready consumer drains. If a word completes while the
// previous word is still unconsumed, the new word is dropped and the sticky
// overrun flag is set.

module serial_word_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             serialInput,
  input  logic             serialValid,
  input  logic             frameStart,
  output logic [WIDTH-1:0] parallelOutput,
  output logic             outValid,
  input  logic             outReady,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    bit_count, bit_count_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             word_done;
  logic             handshake;

  // The consumer takes the held word when both sides agree.
  assign handshake = outValid && outReady;
  assign busy      = (state == SHIFT);

  // State, bit counter and shift register update on strobed edges only.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      bit_count <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      bit_count <= bit_count_next;
      shift_reg <= shift_next;
    end
  end

  // Next-state logic. frameStart outranks everything. WIDTH is at least 2,
  // so a restart never completes a word by itself.
  always_comb begin
    state_next     = state;
    bit_count_next = bit_count;
    shift_next     = shift_reg;
    word_done      = 1'b0;
    if (serialValid) begin
      if (frameStart) begin
        shift_next     = {{(WIDTH-1){1'b0}}, serialInput};
        bit_count_next = CW'(1);
        state_next     = SHIFT;
      end else if (state == SHIFT) begin
        shift_next     = {shift_reg[WIDTH-2:0], serialInput};
        bit_count_next = bit_count + CW'(1);
        if (bit_count_next == LAST_COUNT) begin
          word_done      = 1'b1;
          bit_count_next = '0;
          state_next     = IDLE;
        end
      end
    end
  end

  // Holding register and valid flag. A finished word loads on its last-bit
  // edge when the slot is empty or being drained on that same edge.
  // Otherwise the new word is dropped and the held word stays put.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      parallelOutput <= '0;
      outValid       <= 1'b0;
    end else if (word_done && (!outValid || outReady)) begin
      parallelOutput <= shift_next;
      outValid       <= 1'b1;
    end else if (handshake) begin
      outValid       <= 1'b0;
    end
  end

  // Sticky overrun. Only clr clears it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      overrun <= 1'b0;
    end else if (word_done && outValid && !outReady) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx
// Directed bench for serial_word_rx (WIDTH=8). Inputs change 1 time unit
// after a rising edge. Outputs are sampled at that same point.

module tb_serial_word_rx;

  logic       clk;
  logic       clr;
  logic       serialInput;
  logic       serialValid;
  logic       frameStart;
  logic [7:0] parallelOutput;
  logic       outValid;
  logic       outReady;
  logic       busy;
  logic       overrun;

  int vectors;
  int miscompares;

  serial_word_rx #(.WIDTH(8)) dut (
    .clk            (clk),
    .clr            (clr),
    .serialInput    (serialInput),
    .serialValid    (serialValid),
    .frameStart     (frameStart),
    .parallelOutput (parallelOutput),
    .outValid       (outValid),
    .outReady       (outReady),
    .busy           (busy),
    .overrun        (overrun)
  );

  // 10-unit clock period. Rising edges fall at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, take the rising edge, then return the strobes
  // to idle 1 unit after that edge.
  task automatic applyStimulus(input logic v, input logic fs, input logic d, input logic rdy);
    serialValid = v;
    frameStart  = fs;
    serialInput = d;
    outReady    = rdy;
    @(posedge clk);
    #1;
    serialValid = 1'b0;
    frameStart  = 1'b0;
    serialInput = 1'b0;
    outReady    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Send a full word MSB first, with frameStart on the first bit. outReady is
  // raised only on the edge that takes the last bit.
  task automatic sendWord(input logic [7:0] w, input logic rdyLast);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, (i == 7), w[i], (i == 0) ? rdyLast : 1'b0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_po"},  32'(parallelOutput), 32'h0);
    checkOutput({tag, "_ov"},  32'(outValid),       32'h0);
    checkOutput({tag, "_bsy"}, 32'(busy),           32'h0);
    checkOutput({tag, "_orn"}, 32'(overrun),        32'h0);
  endtask

  initial begin
    logic [7:0] w;
    vectors     = 0;
    miscompares = 0;
    serialInput = 1'b0;
    serialValid = 1'b0;
    frameStart  = 1'b0;
    outReady    = 1'b0;
    clr         = 1'b1;

    // Reset state.
    #12;
    checkAllZero("reset");
    clr = 1'b0;

    // Bits arriving before any frameStart are discarded.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("idle_discard_bsy", 32'(busy), 32'h0);

    // Normal word 0xA5.
    w = 8'hA5;
    for (int i = 7; i >= 1; i--) applyStimulus(1'b1, (i == 7), w[i], 1'b0);
    checkOutput("a5_7bits_bsy", 32'(busy), 32'h1);
    checkOutput("a5_7bits_ov",  32'(outValid), 32'h0);
    applyStimulus(1'b1, 1'b0, w[0], 1'b0);
    checkOutput("a5_po",  32'(parallelOutput), 32'hA5);
    checkOutput("a5_ov",  32'(outValid), 32'h1);
    checkOutput("a5_bsy", 32'(busy), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("a5_drain_ov", 32'(outValid), 32'h0);
    checkOutput("a5_drain_po", 32'(parallelOutput), 32'hA5);

    // Gapped strobes: three idle cycles between bits. frameStart on the idle
    // cycles must be ignored because serialValid is low there.
    w = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b1, (i == 7), w[i], 1'b0);
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          applyStimulus(1'b0, (g == 1), 1'b1, 1'b0);
          checkOutput("gap_bsy", 32'(busy), 32'h1);
          checkOutput("gap_ov",  32'(outValid), 32'h0);
        end
      end
    end
    checkOutput("gap_po",  32'(parallelOutput), 32'hA5);
    checkOutput("gap_ov_done", 32'(outValid), 32'h1);
    checkOutput("gap_bsy_done", 32'(busy), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Resync: five bits of a partial word, then a full 0x3C word.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, (i == 0), 1'b1, 1'b0);
    checkOutput("resync_partial_ov", 32'(outValid), 32'h0);
    sendWord(8'h3C, 1'b0);
    checkOutput("resync_po",  32'(parallelOutput), 32'h3C);
    checkOutput("resync_ov",  32'(outValid), 32'h1);
    checkOutput("resync_orn", 32'(overrun), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back: 0x11 held, and 0x22 completes with outReady on its last edge.
    sendWord(8'h11, 1'b0);
    checkOutput("b2b_first_po", 32'(parallelOutput), 32'h11);
    sendWord(8'h22, 1'b1);
    checkOutput("b2b_po",  32'(parallelOutput), 32'h22);
    checkOutput("b2b_ov",  32'(outValid), 32'h1);
    checkOutput("b2b_orn", 32'(overrun), 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("b2b_drain_ov", 32'(outValid), 32'h0);

    // Overrun: 0x11 held, and 0x22 completes with no ready, so it is dropped.
    sendWord(8'h11, 1'b0);
    sendWord(8'h22, 1'b0);
    checkOutput("orn_po",  32'(parallelOutput), 32'h11);
    checkOutput("orn_ov",  32'(outValid), 32'h1);
    checkOutput("orn_flag", 32'(overrun), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("orn_drain_ov",  32'(outValid), 32'h0);
    checkOutput("orn_sticky",    32'(overrun), 32'h1);
    checkOutput("orn_drain_po",  32'(parallelOutput), 32'h11);

    // outReady with nothing held has no effect.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("noheld_ov", 32'(outValid), 32'h0);
    checkOutput("noheld_po", 32'(parallelOutput), 32'h11);

    // Async clr mid-word, with a held word and overrun set beforehand.
    sendWord(8'h5A, 1'b0);
    checkOutput("pre_clr_po", 32'(parallelOutput), 32'h5A);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, (i == 0), 1'b1, 1'b0);
    #3;
    clr = 1'b1;
    #1;
    checkAllZero("async_clr");
    @(posedge clk);
    #1;
    clr = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkAllZero("post_clr_ignored");

    // A fresh frame after clr works normally. This checks the MSB and LSB
    // boundary bits.
    sendWord(8'h81, 1'b0);
    checkOutput("post_clr_po", 32'(parallelOutput), 32'h81);
    checkOutput("post_clr_ov", 32'(outValid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
